// File: rtl/bram_snap_writer.sv
// Capture engine for the fabric-side write port of the snapshot BRAM: once armed and
// triggered, it writes a programmed number of valid words to addresses 0, 1, 2, ...
module bram_snap_writer #(
  parameter int DEPTH  = 10,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              trig,
  input  logic [DEPTH:0]    capture_len,
  input  logic [DWIDTH-1:0] din,
  input  logic              din_valid,
  output logic              bram_we,
  output logic [DEPTH-1:0]  bram_addr,
  output logic [DWIDTH-1:0] bram_wr_data,
  output logic              busy,
  output logic              done,
  output logic [DEPTH:0]    words_written
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [DEPTH:0] FULL_LEN = {1'b1, {DEPTH{1'b0}}};
  localparam logic [DEPTH:0] ONE      = {{DEPTH{1'b0}}, 1'b1};

  state_t         state_r;
  state_t         state_s;
  logic           arm_q_r;
  logic [DEPTH:0] len_r;
  logic [DEPTH:0] len_eff_s;
  logic [DEPTH:0] count_inc_s;
  logic           arm_edge_s;
  logic           window_s;
  logic           accept_s;
  logic           last_s;

  // Arm edge detection, length normalisation and word acceptance
  always_comb begin
    arm_edge_s  = arm & ~arm_q_r;
    count_inc_s = words_written + ONE;
    if ((capture_len == {(DEPTH+1){1'b0}}) || (capture_len > FULL_LEN)) begin
      len_eff_s = FULL_LEN;
    end else begin
      len_eff_s = capture_len;
    end
    window_s = (state_r == ST_CAPTURE) || ((state_r == ST_ARMED) && trig);
    accept_s = window_s && din_valid && (words_written < len_r) && !arm_edge_s;
    last_s   = accept_s && (count_inc_s == len_r);
  end

  // Next-state logic; an arm edge restarts from ARMED no matter where we are
  always_comb begin
    state_s = state_r;
    if (arm_edge_s) begin
      state_s = ST_ARMED;
    end else begin
      case (state_r)
        ST_IDLE:    state_s = ST_IDLE;
        ST_ARMED: begin
          if (trig) begin
            state_s = last_s ? ST_DONE : ST_CAPTURE;
          end else begin
            state_s = ST_ARMED;
          end
        end
        ST_CAPTURE: begin
          if (last_s) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_CAPTURE;
          end
        end
        ST_DONE:    state_s = ST_DONE;
        default:    state_s = ST_IDLE;
      endcase
    end
  end

  // State, status and BRAM write-port registers. arm_q resets high so an arm
  // held through reset is not mistaken for a fresh rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      arm_q_r       <= 1'b1;
      len_r         <= {(DEPTH+1){1'b0}};
      words_written <= {(DEPTH+1){1'b0}};
      bram_we       <= 1'b0;
      bram_addr     <= {DEPTH{1'b0}};
      bram_wr_data  <= {DWIDTH{1'b0}};
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_r <= state_s;
      arm_q_r <= arm;
      busy    <= (state_s == ST_ARMED) || (state_s == ST_CAPTURE);
      done    <= (state_s == ST_DONE);
      if (arm_edge_s) begin
        len_r         <= len_eff_s;
        words_written <= {(DEPTH+1){1'b0}};
        bram_we       <= 1'b0;
        bram_addr     <= {DEPTH{1'b0}};
      end else if (accept_s) begin
        bram_we       <= 1'b1;
        bram_addr     <= words_written[DEPTH-1:0];
        bram_wr_data  <= din;
        words_written <= count_inc_s;
      end else begin
        bram_we <= 1'b0;
      end
    end
  end

endmodule
